pc_unit: RTL and testbench

//  Parametrised program-counter register; successor to the fixed 32-bit load/hold register.

---
 rtl/pc_unit_pkg.sv | 10 +
 rtl/ras_stack.sv | 60 ++++++
 rtl/pc_unit.sv | 92 +++++++++
 tb/tb_pc_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared next-PC mode encodings for the control unit and the program-counter block.
// Constants only; no logic.
package pc_unit_pkg;

   localparam logic [1:0] PC_SEL_INC    = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
   localparam logic [1:0] PC_SEL_RET    = 2'b11;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack (head pointer plus count); pop-then-push in one cycle replaces the top.
// Push/pop take effect at the clock edge; rdata is the current top, read combinationally from storage.
module ras_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    head_inc;
   logic [PW-1:0]    head_dec;
   logic [CW-1:0]    count;
   logic             eff_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign eff_pop  = pop & ~empty;
   assign unf      = pop & empty;
   assign ovf      = push & full & ~eff_pop;
   assign head_inc = (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
   assign head_dec = (head == '0) ? PW'(DEPTH - 1) : head - PW'(1);
   assign rdata    = mem[head];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         count <= '0;
      end else begin
         if (eff_pop && !push) begin
            head  <= head_dec;
            count <= count - CW'(1);
         end else if (push && !eff_pop) begin
            // When full, advancing head overwrites the oldest entry and the count saturates.
            head <= head_inc;
            if (!full)
               count <= count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[eff_pop ? head : head_inc] <= wdata;
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment/branch/jump/return modes, return-address stack and sticky errors.
// New PC visible one cycle after an enabled edge; contro=0 holds everything except err_clr.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               INC        = 4,
   parameter logic [WIDTH-1:0] RESET_VEC  = '0,
   parameter int               ALIGN_BITS = 2,
   parameter int               RAS_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             contro,
   input  logic [1:0]       pc_sel,
   input  logic             call,
   input  logic             err_clr,
   input  logic [WIDTH-1:0] datain,
   input  logic [WIDTH-1:0] offset,
   output logic [WIDTH-1:0] dataout,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_overflow,
   output logic             ras_underflow
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;

   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] next_pc;
   logic [WIDTH-1:0] ras_top;
   logic             push;
   logic             pop;
   logic             ovf_pulse;
   logic             unf_pulse;

   assign seq_pc = dataout + WIDTH'(INC);
   assign push   = contro & call;
   assign pop    = contro & (pc_sel == PC_SEL_RET);

   ras_stack #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (seq_pc),
      .rdata (ras_top),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ovf_pulse),
      .unf   (unf_pulse)
   );

   always_comb begin
      next_pc = seq_pc;
      case (pc_sel)
         PC_SEL_INC:    next_pc = seq_pc;
         PC_SEL_BRANCH: next_pc = dataout + offset;
         PC_SEL_JUMP:   next_pc = datain;
         PC_SEL_RET:    next_pc = ras_empty ? seq_pc : ras_top;
         default:       next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dataout <= RESET_VEC;
      else if (contro)
         dataout <= next_pc & ALIGN_MASK;
   end

   // A fresh error in the clearing cycle takes priority over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         if (err_clr) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
         end
         if (ovf_pulse)
            ras_overflow <= 1'b1;
         if (unf_pulse)
            ras_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a queue-based reference model.
module tb_pc_unit;

   logic        clk;
   logic        reset;
   logic        contro;
   logic [1:0]  pc_sel;
   logic        call;
   logic        err_clr;
   logic [31:0] datain;
   logic [31:0] offset;
   logic [31:0] dataout;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_overflow;
   logic        ras_underflow;

   int checks = 0;
   int errors = 0;

   // Reference model: PC value, return stack as a queue (back = top), sticky flags.
   logic [31:0] m_pc;
   logic [31:0] m_stk[$];
   logic        m_ovf;
   logic        m_unf;

   pc_unit #(
      .WIDTH      (32),
      .INC        (4),
      .RESET_VEC  (32'h0),
      .ALIGN_BITS (2),
      .RAS_DEPTH  (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .contro        (contro),
      .pc_sel        (pc_sel),
      .call          (call),
      .err_clr       (err_clr),
      .datain        (datain),
      .offset        (offset),
      .dataout       (dataout),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input logic c, input logic [1:0] s, input logic cl,
                             input logic ec, input logic [31:0] din, input logic [31:0] off);
      logic [31:0] ret;
      logic [31:0] npc;
      if (ec) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (c) begin
         ret = m_pc + 32'd4;
         npc = ret;
         if (s == 2'd1)
            npc = m_pc + off;
         else if (s == 2'd2)
            npc = din;
         else if (s == 2'd3) begin
            if (m_stk.size() > 0)
               npc = m_stk.pop_back();
            else
               m_unf = 1'b1;
         end
         if (cl) begin
            if (m_stk.size() == 4) begin
               void'(m_stk.pop_front());
               m_ovf = 1'b1;
            end
            m_stk.push_back(ret);
         end
         m_pc = {npc[31:2], 2'b00};
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_pc"},    dataout,                    m_pc);
      chk({tag, "_empty"}, {31'b0, ras_empty},         {31'b0, m_stk.size() == 0});
      chk({tag, "_full"},  {31'b0, ras_full},          {31'b0, m_stk.size() == 4});
      chk({tag, "_ovf"},   {31'b0, ras_overflow},      {31'b0, m_ovf});
      chk({tag, "_unf"},   {31'b0, ras_underflow},     {31'b0, m_unf});
   endtask

   task automatic step(input string tag, input logic c, input logic [1:0] s, input logic cl,
                       input logic ec, input logic [31:0] din, input logic [31:0] off);
      contro  = c;
      pc_sel  = s;
      call    = cl;
      err_clr = ec;
      datain  = din;
      offset  = off;
      @(posedge clk);
      model_step(c, s, cl, ec, din, off);
      #1;
      chk_all(tag);
   endtask

   initial begin
      reset   = 1'b1;
      contro  = 1'b0;
      pc_sel  = 2'd0;
      call    = 1'b0;
      err_clr = 1'b0;
      datain  = '0;
      offset  = '0;
      model_reset();

      #20;
      chk_all("in_reset");
      #30;
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 3; i++)
         step("idle", 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t1_pc", dataout, 32'h0);
      chk("t1_empty", {31'b0, ras_empty}, 32'h1);

      // Increment, wrapping branch, hold
      step("inc1", 1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_inc1", dataout, 32'h4);
      step("inc2", 1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_inc2", dataout, 32'h8);
      step("br", 1'b1, 2'd1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8);
      chk("t2_branch_wrap", dataout, 32'h0);
      step("hold", 1'b0, 2'd2, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
      chk("t2_hold", dataout, 32'h0);

      // Aligned jump, call, return
      step("jmp", 1'b1, 2'd2, 1'b0, 1'b0, 32'h107, 32'h0);
      chk("t3_align", dataout, 32'h104);
      step("jcall", 1'b1, 2'd2, 1'b1, 1'b0, 32'h200, 32'h0);
      chk("t3_jcall", dataout, 32'h200);
      step("ret", 1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t3_ret", dataout, 32'h108);
      chk("t3_ret_empty", {31'b0, ras_empty}, 32'h1);

      // Fill, overflow, drain, underflow, clear
      step("to0", 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 1; i <= 5; i++) begin
         step("call", 1'b1, 2'd2, 1'b1, 1'b0, 32'h1000 * i, 32'h0);
         if (i == 4)
            chk("t4_full4", {31'b0, ras_full}, 32'h1);
      end
      chk("t4_ovf", {31'b0, ras_overflow}, 32'h1);
      for (int i = 4; i >= 1; i--) begin
         step("drain", 1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0);
         chk("t4_drain", dataout, 32'h1000 * i + 32'h4);
      end
      step("unf", 1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t4_unf_pc", dataout, 32'h1008);
      chk("t4_unf", {31'b0, ras_underflow}, 32'h1);
      step("clr", 1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
      chk("t4_clr", {30'b0, ras_overflow, ras_underflow}, 32'h0);
      step("clr_vs_err", 1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0);
      chk("clr_loses", {31'b0, ras_underflow}, 32'h1);
      step("clr2", 1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0);

      // RET+call with a single entry replaces the top
      step("to104", 1'b1, 2'd2, 1'b0, 1'b0, 32'h104, 32'h0);
      step("c300", 1'b1, 2'd2, 1'b1, 1'b0, 32'h300, 32'h0);
      step("retcall", 1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 32'h0);
      chk("t5_pc", dataout, 32'h108);
      step("ret304", 1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("t5_top", dataout, 32'h304);
      chk("t5_count1", {31'b0, ras_empty}, 32'h1);

      // Asynchronous reset between edges
      step("c200", 1'b1, 2'd2, 1'b1, 1'b0, 32'h200, 32'h0);
      step("c200b", 1'b1, 2'd2, 1'b1, 1'b0, 32'h200, 32'h0);
      pc_sel = 2'd0;
      call   = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      chk("t6_pc", dataout, 32'h0);
      chk("t6_empty", {31'b0, ras_empty}, 32'h1);
      chk_all("t6");
      #1;
      reset = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] r;
         r = $urandom;
         step("rnd", r[1:0] != 2'd0, r[3:2], r[5:4] == 2'd0, r[8:6] == 3'd0,
              $urandom, (r[9] ? $urandom : {{20{r[31]}}, r[31:20]}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
